// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared constants and types for the Hack data-memory stage
package hack_mem_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int FB_ADDR_W = 12;

  // Hack memory map: screen image starts here, keyboard register is the last word
  localparam logic [ADDR_W-1:0] SCREEN_BASE = 14'h3000;
  localparam logic [ADDR_W-1:0] KBD_ADDR    = 14'h3FFF;

  // One posted framebuffer write: word offset inside the screen plus its data
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    data;
  } fb_entry_t;

  localparam int FB_ENTRY_W = $bits(fb_entry_t);

  // True for addresses in the screen image (keyboard word excluded)
  function automatic logic in_screen(input logic [ADDR_W-1:0] addr);
    return (addr >= SCREEN_BASE) && (addr < KBD_ADDR);
  endfunction

  // Screen word offset; only the low FB_ADDR_W bits of the difference matter
  function automatic logic [FB_ADDR_W-1:0] screen_offset(input logic [ADDR_W-1:0] addr);
    return addr[FB_ADDR_W-1:0] - SCREEN_BASE[FB_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/hack_sync_fifo.sv
// rtl/hack_sync_fifo.sv - single-clock FIFO with level count and push-while-full-and-popping
module hack_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] slots_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = slots_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO may still take a push
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level state; storage contents are left alone on reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage written at the tail
  always_ff @(posedge clk) begin
    if (resetn && do_push) begin
      slots_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/hack_data_mem_ctrl.sv
// rtl/hack_data_mem_ctrl.sv - Hack data memory: local RAM, keyboard register, posted screen writes
module hack_data_mem_ctrl
  import hack_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   outM,
  input  logic [13:0]                   addressM,
  input  logic                          writeM,
  input  logic [13:0]                   rd_addr,
  output logic [15:0]                   inM,
  input  logic [15:0]                   kbd_code,
  input  logic                          kbd_strobe,
  input  logic                          kbd_release,
  output logic [11:0]                   fb_addr,
  output logic [15:0]                   fb_data,
  output logic                          fb_valid,
  input  logic                          fb_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_cnt
);

  logic [DATA_W-1:0] ram_q [2**ADDR_W];
  logic              ram_we;

  logic [DATA_W-1:0] key_q, key_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              push_req;
  logic              pop_req;
  logic              fifo_full;
  logic              fifo_empty;
  fb_entry_t         push_entry;
  fb_entry_t         head_entry;

  // Reads are combinational, so a same-cycle write is only seen from the next cycle
  assign inM = (rd_addr == KBD_ADDR) ? key_q : ram_q[rd_addr];

  // Decode the CPU write bundle into RAM write, FIFO push and drop accounting
  always_comb begin
    ram_we           = reset && writeM && (addressM != KBD_ADDR);
    push_req         = reset && writeM && in_screen(addressM);
    push_entry.addr  = screen_offset(addressM);
    push_entry.data  = outM;
    pop_req          = fb_valid && fb_ready;
    drop_d           = drop_q;
    if (push_req && fifo_full && !pop_req && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // Keyboard register: a new key beats a release arriving in the same cycle
  always_comb begin
    key_d = key_q;
    if (kbd_strobe) begin
      key_d = kbd_code;
    end else if (kbd_release) begin
      key_d = '0;
    end
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q  <= '0;
      drop_q <= '0;
    end else begin
      key_q  <= key_d;
      drop_q <= drop_d;
    end
  end

  // Local RAM (general RAM plus screen image); never cleared
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[addressM] <= outM;
    end
  end

  hack_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FB_ENTRY_W)
  ) u_fb_fifo (
    .clk       (clk),
    .resetn    (reset),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (head_entry)
  );

  // Head is presented straight from FIFO storage; zeroed while empty so stale slots never leak
  assign fb_valid = !fifo_empty;
  assign fb_addr  = fifo_empty ? '0 : head_entry.addr;
  assign fb_data  = fifo_empty ? '0 : head_entry.data;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_hack_data_mem_ctrl.sv
// tb/tb_hack_data_mem_ctrl.sv - directed and randomized checks against a queue-based model
module tb_hack_data_mem_ctrl;

  localparam logic [13:0] SB    = 14'h3000;
  localparam logic [13:0] KBD   = 14'h3FFF;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] outM;
  logic [13:0] addressM;
  logic        writeM;
  logic [13:0] rd_addr;
  logic [15:0] inM;
  logic [15:0] kbd_code;
  logic        kbd_strobe;
  logic        kbd_release;
  logic [11:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_valid;
  logic        fb_ready;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [15:0] m_mem [int];
  logic [27:0] m_q [$];
  int          m_drop = 0;
  logic [15:0] m_key  = '0;

  always #5 clk = ~clk;

  hack_data_mem_ctrl #(.FIFO_DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .outM        (outM),
    .addressM    (addressM),
    .writeM      (writeM),
    .rd_addr     (rd_addr),
    .inM         (inM),
    .kbd_code    (kbd_code),
    .kbd_strobe  (kbd_strobe),
    .kbd_release (kbd_release),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_valid    (fb_valid),
    .fb_ready    (fb_ready),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag);
    if (rd_addr == KBD) check(tag, inM, m_key);
    else if (m_mem.exists(int'(rd_addr))) check(tag, inM, m_mem[int'(rd_addr)]);
  endtask

  task automatic check_state();
    check("fb_valid", fb_valid, m_q.size() != 0);
    check("fifo_level", fifo_level, m_q.size());
    check("drop_cnt", drop_cnt, m_drop);
    if (m_q.size() != 0) begin
      check("fb_addr", fb_addr, m_q[0][27:16]);
      check("fb_data", fb_data, m_q[0][15:0]);
    end else begin
      check("fb_addr_idle", fb_addr, 0);
      check("fb_data_idle", fb_data, 0);
    end
    read_check("inM_post");
  endtask

  // Advance one clock: pre-edge read check, model update from current inputs, post-edge checks
  task automatic tick();
    logic was_full, pop, push;
    #1;
    if (reset) read_check("inM_pre");
    if (!reset) begin
      m_q.delete();
      m_drop = 0;
      m_key  = '0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      pop      = (m_q.size() != 0) && fb_ready;
      push     = writeM && (addressM >= SB) && (addressM < KBD);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!was_full || pop) m_q.push_back({12'(addressM - SB), outM});
        else if (m_drop < 255) m_drop++;
      end
      if (writeM && addressM != KBD) m_mem[int'(addressM)] = outM;
      if (kbd_strobe) m_key = kbd_code;
      else if (kbd_release) m_key = '0;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle();
    writeM      = 1'b0;
    kbd_strobe  = 1'b0;
    kbd_release = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    writeM   = 1'b1;
    addressM = a;
    outM     = d;
    tick();
    writeM   = 1'b0;
  endtask

  function automatic logic [13:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 14'($urandom_range(0, 15));
    if (r < 9) return SB + 14'($urandom_range(0, 15));
    return KBD;
  endfunction

  initial begin
    reset = 1'b0; outM = '0; addressM = '0; writeM = 1'b0; rd_addr = KBD;
    kbd_code = '0; kbd_strobe = 1'b0; kbd_release = 1'b0; fb_ready = 1'b0;

    // 1: reset
    tick(); tick();
    check("rst_fb_valid", fb_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_key", inM, 0);
    reset = 1'b1;

    // 2: RAM write, old value same cycle, new value next cycle
    rd_addr = 14'h0010;
    wr(14'h0010, 16'h1111);
    writeM = 1'b1; addressM = 14'h0010; outM = 16'h1234;
    #1;
    check("rdw_old", inM, 16'h1111);
    tick();
    idle();
    check("rdw_new", inM, 16'h1234);
    check("ram_no_post", fb_valid, 0);

    // 3: single screen write posted and popped
    fb_ready = 1'b1;
    wr(14'h3005, 16'hBEEF);
    check("scr_valid", fb_valid, 1);
    check("scr_addr", fb_addr, 12'h005);
    check("scr_data", fb_data, 16'hBEEF);
    tick();
    check("scr_popped", fifo_level, 0);

    // 4: overflow with fb_ready low, then drain in order
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(SB + 14'(i), 16'hA000 + 16'(i));
    check("ovf_level", fifo_level, 4);
    check("ovf_drop", drop_cnt, 2);
    fb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", fb_data, 16'hA000 + 16'(i));
      tick();
    end
    check("drain_empty", fb_valid, 0);

    // 5: push and pop together while full
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(14'h3010 + 14'(i), 16'hB000 + 16'(i));
    fb_ready = 1'b1;
    wr(14'h3100, 16'hC0DE);
    check("pp_level", fifo_level, 4);
    check("pp_drop", drop_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        check("pp_tail_addr", fb_addr, 12'h100);
        check("pp_tail_data", fb_data, 16'hC0DE);
      end
      tick();
    end

    // 6: keyboard register
    rd_addr = KBD;
    kbd_code = 16'h0041; kbd_strobe = 1'b1; tick(); idle();
    check("kbd_strobe", inM, 16'h0041);
    kbd_code = 16'h0042; kbd_strobe = 1'b1; kbd_release = 1'b1; tick(); idle();
    check("kbd_both", inM, 16'h0042);
    kbd_release = 1'b1; tick(); idle();
    check("kbd_release", inM, 16'h0000);
    kbd_code = 16'h0055; kbd_strobe = 1'b1; tick(); idle();
    fb_ready = 1'b0;
    wr(KBD, 16'hFFFF);
    check("kbd_wr_key", inM, 16'h0055);
    check("kbd_wr_fifo", fifo_level, 0);

    // reset with entries queued
    for (int i = 0; i < 3; i++) wr(14'h3020 + 14'(i), 16'hD000 + 16'(i));
    check("q3_level", fifo_level, 3);
    reset = 1'b0; tick(); reset = 1'b1;
    check("rstq_valid", fb_valid, 0);
    check("rstq_level", fifo_level, 0);

    // drop counter saturation
    for (int i = 0; i < DEPTH + 260; i++) wr(SB + 14'(i % 16), 16'(i));
    check("sat_drop", drop_cnt, 8'hFF);
    fb_ready = 1'b1;
    wr(SB, 16'h7777);
    check("sat_hold", drop_cnt, 8'hFF);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 79) != 0);
      writeM      = $urandom_range(0, 1) == 1;
      addressM    = pick_addr();
      outM        = 16'($urandom);
      rd_addr     = ($urandom_range(0, 3) == 0) ? addressM : pick_addr();
      fb_ready    = $urandom_range(0, 2) == 0;
      kbd_strobe  = $urandom_range(0, 7) == 0;
      kbd_release = $urandom_range(0, 7) == 0;
      kbd_code    = 16'($urandom);
      tick();
    end
    reset = 1'b1;
    idle();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
